// File: rtl/priv_clint_timer_if.sv
// Request/busy bus into the CLINT window; the requester drives address, strobes and write data.
// Read data is meaningful only in the cycle after busy was high.
interface priv_clint_timer_if;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output addr, ren, wen, byte_en, wdata,
        input  rdata, busy
    );

    modport slave (
        input  addr, ren, wen, byte_en, wdata,
        output rdata, busy
    );
endinterface

// File: rtl/priv_clint_timer.sv
// Machine-mode CLINT: mtime, mtimecmp and msip on a request/busy bus, feeding timer/software interrupts.
// Each claimed access takes 2 cycles (busy in IDLE, data/commit in ACCESS); misses are never claimed.
module priv_clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    priv_clint_timer_if.slave bus,
    output logic              timer_int_m,
    output logic              soft_int_m,
    output logic              clear_timer_int_m,
    output logic              clear_soft_int_m
);

    localparam logic [15:0] OFF_MSIP   = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MT_LO  = 16'hBFF8;
    localparam logic [15:0] OFF_MT_HI  = 16'hBFFC;
    localparam logic [15:0] PRE_MAX    = 16'(PRESCALE - 1);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_off;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_ren;
    logic        r_wen;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [15:0] r_pre;

    logic        w_hit;
    logic        w_busy;
    logic        w_latch;
    logic        w_commit;
    logic        w_tick;
    logic        w_cmp_hit;
    logic [31:0] w_rd_val;
    logic        w_unused;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_hit    = (bus.addr[31:16] == BASE_ADDR[31:16]);
    assign w_unused = &{1'b0, bus.addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((bus.ren | bus.wen) & w_hit) begin
                    w_busy      = 1'b1;
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy = w_busy;
    assign w_commit = (r_state == ST_ACCESS) & r_wen;

    // Read data comes from live register values, so an mtime read sees the current count.
    always_comb begin
        w_rd_val = 32'd0;
        case (r_off)
            OFF_MSIP:   w_rd_val = {31'd0, r_msip};
            OFF_CMP_LO: w_rd_val = r_mtimecmp[31:0];
            OFF_CMP_HI: w_rd_val = r_mtimecmp[63:32];
            OFF_MT_LO:  w_rd_val = r_mtime[31:0];
            OFF_MT_HI:  w_rd_val = r_mtime[63:32];
            default:    w_rd_val = 32'd0;
        endcase
    end

    assign bus.rdata = ((r_state == ST_ACCESS) && r_ren) ? w_rd_val : 32'd0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_off   <= 16'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_off   <= {bus.addr[15:2], 2'b00};
                r_wdata <= bus.wdata;
                r_be    <= bus.byte_en;
                r_ren   <= bus.ren;
                r_wen   <= bus.wen;
            end
        end
    end

    assign w_tick = (r_pre == PRE_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pre <= 16'd0;
        end else begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        end
    end

    // A software write to either half replaces that cycle's increment; no carry crosses halves.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mtime <= 64'd0;
        end else if (w_commit && (r_off == OFF_MT_LO)) begin
            r_mtime[31:0] <= merge_lanes(r_mtime[31:0], r_wdata, r_be);
        end else if (w_commit && (r_off == OFF_MT_HI)) begin
            r_mtime[63:32] <= merge_lanes(r_mtime[63:32], r_wdata, r_be);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
        end else begin
            if (w_commit && (r_off == OFF_CMP_LO))
                r_mtimecmp[31:0] <= merge_lanes(r_mtimecmp[31:0], r_wdata, r_be);
            if (w_commit && (r_off == OFF_CMP_HI))
                r_mtimecmp[63:32] <= merge_lanes(r_mtimecmp[63:32], r_wdata, r_be);
            if (w_commit && (r_off == OFF_MSIP) && r_be[0])
                r_msip <= r_wdata[0];
        end
    end

    assign w_cmp_hit = (r_mtime >= r_mtimecmp);

    // Clear pulses rise in the same cycle the pending line drops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            timer_int_m       <= 1'b0;
            soft_int_m        <= 1'b0;
            clear_timer_int_m <= 1'b0;
            clear_soft_int_m  <= 1'b0;
        end else begin
            timer_int_m       <= w_cmp_hit;
            soft_int_m        <= r_msip;
            clear_timer_int_m <= timer_int_m & ~w_cmp_hit;
            clear_soft_int_m  <= soft_int_m & ~r_msip;
        end
    end

endmodule

// File: tb/tb_priv_clint_timer.sv
// Drives two CLINTs (PRESCALE 1 and 4) with one bus stream; a monitor checks reads and interrupt
// lines against an arithmetic model of mtime (value = last write + elapsed prescale periods).
module tb_priv_clint_timer;
    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam int P0 = 1;
    localparam int P1 = 4;
    localparam logic [15:0] OFFS [6] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0010};

    logic CLK;
    logic nRST;
    priv_clint_timer_if bus0();
    priv_clint_timer_if bus1();

    logic [1:0]  tint, tclr, sint, sclr, busy_a;
    logic [31:0] rdata_a [2];

    assign bus1.addr    = bus0.addr;
    assign bus1.ren     = bus0.ren;
    assign bus1.wen     = bus0.wen;
    assign bus1.byte_en = bus0.byte_en;
    assign bus1.wdata   = bus0.wdata;
    assign busy_a[0]    = bus0.busy;
    assign busy_a[1]    = bus1.busy;
    assign rdata_a[0]   = bus0.rdata;
    assign rdata_a[1]   = bus1.rdata;

    priv_clint_timer #(.BASE_ADDR(BASE), .PRESCALE(P0)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .bus(bus0),
        .timer_int_m(tint[0]), .soft_int_m(sint[0]),
        .clear_timer_int_m(tclr[0]), .clear_soft_int_m(sclr[0])
    );

    priv_clint_timer #(.BASE_ADDR(BASE), .PRESCALE(P1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .bus(bus1),
        .timer_int_m(tint[1]), .soft_int_m(sint[1]),
        .clear_timer_int_m(tclr[1]), .clear_soft_int_m(sclr[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks;
    int failures;
    int n;
    logic [63:0] m_base [2];
    int          m_base_n [2];
    logic [63:0] m_cmp;
    logic        m_msip;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) n <= 0;
        else       n <= n + 1;
    end

    function automatic int pval(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    // mtime after k clock edges since reset release
    function automatic logic [63:0] mtime_at(input int i, input int k);
        return m_base[i] + 64'(k / pval(i)) - 64'(m_base_n[i] / pval(i));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] read_model(input int i, input logic [15:0] off, input int k);
        logic [63:0] mt;
        mt = mtime_at(i, k);
        case (off & 16'hFFFC)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return mt[31:0];
            16'hBFFC: return mt[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i]   = 64'd0;
            m_base_n[i] = 0;
        end
        m_cmp  = '1;
        m_msip = 1'b0;
    endtask

    // write committed at edge e: state seen during ACCESS is the value after e-1 edges
    task automatic apply_write(input logic [15:0] off, input logic [31:0] d, input logic [3:0] be, input int e);
        logic [63:0] cur;
        case (off & 16'hFFFC)
            16'h0000: if (be[0]) m_msip = d[0];
            16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], d, be);
            16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], d, be);
            16'hBFF8: for (int i = 0; i < 2; i++) begin
                cur = mtime_at(i, e - 1);
                m_base[i]   = {cur[63:32], merge(cur[31:0], d, be)};
                m_base_n[i] = e;
            end
            16'hBFFC: for (int i = 0; i < 2; i++) begin
                cur = mtime_at(i, e - 1);
                m_base[i]   = {merge(cur[63:32], d, be), cur[31:0]};
                m_base_n[i] = e;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, i, act, exp, $time);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // called at posedge+1; returns at posedge+1 right after the commit edge
    task automatic access(input logic is_wr, input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        int   a;
        logic hit;
        a   = n;
        hit = (addr[31:16] == BASE[31:16]);
        bus0.addr    = addr;
        bus0.ren     = !is_wr;
        bus0.wen     = is_wr;
        bus0.wdata   = d;
        bus0.byte_en = be;
        if (hit && !is_wr) begin
            q0.push_back(read_model(0, addr[15:0], a + 1));
            q1.push_back(read_model(1, addr[15:0], a + 1));
        end
        @(posedge CLK);
        #1;
        bus0.ren = 1'b0;
        bus0.wen = 1'b0;
        @(posedge CLK);
        #1;
        if (hit && is_wr) apply_write(addr[15:0], d, be, a + 2);
    endtask

    task automatic rd(input logic [31:0] addr);
        access(1'b0, addr, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
        access(1'b1, addr, d, be);
    endtask

    logic tf1 [2], tf2 [2], mf1 [2], mf2 [2], acc [2], acc_rd [2];

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic        eb;
            logic [31:0] ev;
            if (!nRST) begin
                chk("reset_outputs", i, {busy_a[i], tint[i], tclr[i], sint[i], sclr[i]}, 64'd0);
                tf1[i] = 1'b0; tf2[i] = 1'b0; mf1[i] = 1'b0; mf2[i] = 1'b0;
                acc[i] = 1'b0; acc_rd[i] = 1'b0;
            end else begin
                chk("timer_int_m", i, tint[i], tf1[i]);
                chk("clear_timer_int_m", i, tclr[i], tf2[i] & ~tf1[i]);
                chk("soft_int_m", i, sint[i], mf1[i]);
                chk("clear_soft_int_m", i, sclr[i], mf2[i] & ~mf1[i]);
                tf2[i] = tf1[i];
                tf1[i] = (mtime_at(i, n) >= m_cmp);
                mf2[i] = mf1[i];
                mf1[i] = m_msip;
                if (acc[i]) begin
                    chk("access_busy", i, busy_a[i], 64'd0);
                    if (acc_rd[i]) begin
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL rdata_queue dut%0d actual=empty required=entry t=%0t", i, $time);
                        end else begin
                            if (i == 0) ev = q0.pop_front();
                            else        ev = q1.pop_front();
                            chk("rdata", i, rdata_a[i], ev);
                        end
                    end
                    acc[i] = 1'b0;
                end else begin
                    eb = (bus0.ren | bus0.wen) && (bus0.addr[31:16] == BASE[31:16]);
                    chk("idle_busy", i, busy_a[i], eb);
                    if ((bus0.ren | bus0.wen) && !eb) chk("miss_rdata", i, rdata_a[i], 64'd0);
                    if (eb) begin
                        acc[i]    = 1'b1;
                        acc_rd[i] = bus0.ren;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] off;
        logic [31:0] addr, d;
        logic        is_wr;
        checks = 0;
        failures = 0;
        bus0.addr = 32'd0; bus0.ren = 1'b0; bus0.wen = 1'b0;
        bus0.byte_en = 4'd0; bus0.wdata = 32'd0;
        nRST = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();

        idle(10);
        rd(BASE + 32'hBFF8);
        rd(BASE + 32'hBFFC);

        wr(BASE + 32'h4004, 32'd0, 4'hF);
        wr(BASE + 32'h4000, 32'd20, 4'hF);
        idle(70);
        wr(BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
        idle(3);

        wr(BASE, 32'd1, 4'b0001);
        idle(3);
        wr(BASE, 32'd0, 4'b0001);
        idle(3);
        wr(BASE, 32'd1, 4'b0000);
        idle(2);
        rd(BASE);

        wr(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'hBFF8);
        rd(BASE + 32'hBFFC);
        idle(4);
        rd(BASE + 32'hBFF8);
        rd(BASE + 32'hBFFC);

        for (int k = 0; k < 4 && ((n + 2) % P1) != 0; k++) idle(1);
        wr(BASE + 32'hBFF8, 32'd5, 4'hF);
        rd(BASE + 32'hBFF8);
        idle(1);
        rd(BASE + 32'hBFF8);
        rd(BASE + 32'hBFF8);

        rd(BASE + 32'h0010);
        wr(BASE + 32'h0010, 32'hDEAD_BEEF, 4'hF);
        rd(BASE + 32'h1_0000);
        wr(BASE + 32'h1_4000, 32'd0, 4'hF);
        rd(BASE + 32'h4000);

        bus0.addr = BASE + 32'h4000; bus0.wdata = 32'd0; bus0.byte_en = 4'hF; bus0.wen = 1'b1;
        @(posedge CLK);
        #1;
        bus0.wen = 1'b0;
        nRST = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_reset();
        rd(BASE + 32'h4000);
        rd(BASE + 32'h4004);
        rd(BASE + 32'hBFF8);

        repeat (300) begin
            off = OFFS[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) off = 16'($urandom);
            addr  = {($urandom_range(0, 15) == 0) ? 16'hF001 : BASE[31:16], off[15:2], 2'($urandom)};
            is_wr = 1'($urandom);
            d     = $urandom;
            if (off == 16'h4004 || off == 16'hBFFC) d = ($urandom_range(0, 3) == 0) ? d : 32'd0;
            if (off == 16'h4000 && $urandom_range(0, 1) == 0) d = $urandom_range(0, 3000);
            if (is_wr) wr(addr, d, 4'($urandom));
            else       rd(addr);
            idle($urandom_range(0, 3));
        end

        idle(5);
        chk("queue_drained", 0, 64'(q0.size()), 64'd0);
        chk("queue_drained", 1, 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
